ccff_chain_loader: RTL



---
 rtl/ccff_pkg.sv | 21 ++
 rtl/ccff_crc8.sv | 24 ++
 rtl/ccff_chain_loader.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ccff_pkg.sv
// Shared types and CRC helper for the configuration-chain loader.
// The CRC is serial CRC-8 with polynomial 0x07, init 0x00 and no final XOR.
package ccff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_VERIFY,
        ST_FIN
    } ccff_ld_state_t;

    localparam logic [7:0] CCFF_CRC_POLY = 8'h07;

    // One serial CRC-8 step: the feedback bit is the top CRC bit XOR the incoming bit.
    function automatic logic [7:0] ccff_crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? CCFF_CRC_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/ccff_crc8.sv
// Serial CRC-8 accumulator with synchronous clear and enable.
// Clear has priority over enable.
module ccff_crc8
    import ccff_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= 8'h00;
        end else if (clr) begin
            crc <= 8'h00;
        end else if (en) begin
            crc <= ccff_crc8_step(crc, din);
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Serializes host configuration words into a scan chain of configuration flops,
// with an optional recirculating verify pass that compares CRCs of the bits in and out.
module ccff_chain_loader
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 8,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              cfg_start,
    input  logic              cfg_verify,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_clk_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int BCW       = $clog2(CHAIN_LEN + 1);
    localparam int FW        = $clog2(WORD_W + 1);
    localparam int WORDS     = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int WCW       = $clog2(WORDS + 1);
    localparam int LAST_BITS = CHAIN_LEN - (WORDS - 1) * WORD_W;

    localparam logic [BCW-1:0] LAST_IDX  = BCW'(CHAIN_LEN - 1);
    localparam logic [WCW-1:0] WORDS_C   = WCW'(WORDS);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS - 1);
    localparam logic [FW-1:0]  FULL_FILL = FW'(WORD_W);
    localparam logic [FW-1:0]  LAST_FILL = FW'(LAST_BITS);
    localparam logic [FW-1:0]  ONE_FILL  = FW'(1);

    ccff_ld_state_t    state, state_n;
    logic [WORD_W-1:0] shift_buf, shift_buf_n;
    logic [FW-1:0]     fill, fill_n;
    logic [WCW-1:0]    word_cnt, word_cnt_n;
    logic [BCW-1:0]    bit_cnt, bit_cnt_n;
    logic              verify_q, verify_n;
    logic              err_q, err_n;
    logic              head_q, head_n;
    logic              en_q, en_n;

    logic              crc_clr;
    logic              crc_in_en;
    logic              crc_out_en;
    logic [7:0]        crc_in_val;
    logic [7:0]        crc_out_val;

    ccff_crc8 u_crc_in (
        .clk (prog_clk),
        .rst (prog_reset),
        .clr (crc_clr),
        .en  (crc_in_en),
        .din (shift_buf[0]),
        .crc (crc_in_val)
    );

    ccff_crc8 u_crc_out (
        .clk (prog_clk),
        .rst (prog_reset),
        .clr (crc_clr),
        .en  (crc_out_en),
        .din (ccff_tail),
        .crc (crc_out_val)
    );

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state     <= ST_IDLE;
            shift_buf <= '0;
            fill      <= '0;
            word_cnt  <= '0;
            bit_cnt   <= '0;
            verify_q  <= 1'b0;
            err_q     <= 1'b0;
            head_q    <= 1'b0;
            en_q      <= 1'b0;
        end else begin
            state     <= state_n;
            shift_buf <= shift_buf_n;
            fill      <= fill_n;
            word_cnt  <= word_cnt_n;
            bit_cnt   <= bit_cnt_n;
            verify_q  <= verify_n;
            err_q     <= err_n;
            head_q    <= head_n;
            en_q      <= en_n;
        end
    end

    // A refill may land on the same edge that shifts out the buffer's last bit,
    // so the accept branch overrides the shift branch for the buffer and fill count.
    always_comb begin
        state_n     = state;
        shift_buf_n = shift_buf;
        fill_n      = fill;
        word_cnt_n  = word_cnt;
        bit_cnt_n   = bit_cnt;
        verify_n    = verify_q;
        err_n       = err_q;
        crc_clr     = 1'b0;
        crc_in_en   = 1'b0;
        crc_out_en  = 1'b0;
        cfg_ready   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_n    = ST_LOAD;
                    bit_cnt_n  = '0;
                    word_cnt_n = '0;
                    fill_n     = '0;
                    err_n      = 1'b0;
                    verify_n   = cfg_verify;
                    crc_clr    = 1'b1;
                end
            end
            ST_LOAD: begin
                cfg_ready = ((fill == '0) || (fill == ONE_FILL)) && (word_cnt != WORDS_C);
                if (fill != '0) begin
                    crc_in_en   = 1'b1;
                    shift_buf_n = shift_buf >> 1;
                    fill_n      = fill - ONE_FILL;
                    bit_cnt_n   = bit_cnt + BCW'(1);
                    if (bit_cnt == LAST_IDX) begin
                        state_n   = verify_q ? ST_VERIFY : ST_FIN;
                        bit_cnt_n = '0;
                    end
                end
                if (cfg_ready && cfg_valid) begin
                    shift_buf_n = cfg_data;
                    fill_n      = (word_cnt == LAST_WORD) ? LAST_FILL : FULL_FILL;
                    word_cnt_n  = word_cnt + WCW'(1);
                end
            end
            ST_VERIFY: begin
                crc_out_en = 1'b1;
                bit_cnt_n  = bit_cnt + BCW'(1);
                if (bit_cnt == LAST_IDX) begin
                    state_n   = ST_FIN;
                    bit_cnt_n = '0;
                    if (ccff_crc8_step(crc_out_val, ccff_tail) != crc_in_val) begin
                        err_n = 1'b1;
                    end
                end
            end
            ST_FIN: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        head_n = ((state_n == ST_LOAD) && (fill_n != '0)) ? shift_buf_n[0] : 1'b0;
        en_n   = ((state_n == ST_LOAD) && (fill_n != '0)) || (state_n == ST_VERIFY);
    end

    // Recirculation in verify is the only combinational tail-to-head path.
    assign ccff_head   = (state == ST_VERIFY) ? ccff_tail : head_q;
    assign ccff_clk_en = en_q;
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_FIN);
    assign err         = err_q;

endmodule
